// File: rtl/disp_timing_pkg.sv
// Shared display timing constants: default panel timing, counter width
// and the line/frame total helper used by disp_timing_gen.
package disp_timing_pkg;

  localparam int CNT_W = 12;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 160;
  localparam int DEF_H_SYNC   = 20;
  localparam int DEF_H_BP     = 140;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 12;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 20;

  function automatic int axis_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP,
                                          DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP,
                                          DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/disp_timing_gen_axis_cnt.sv
// tg_axis_cnt: modulo-MODULO counter with synchronous clear and a
// combinational wrap-out that is high when an increment rolls it over.
// Ports: clk_i, rst_i, clr_i, inc_i -> cnt_o, wrap_o.
module tg_axis_cnt
  import disp_timing_pkg::*;
#(
  parameter int MODULO = DEF_H_TOTAL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULO - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap_o = inc_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/disp_timing_gen.sv
// Display timing generator: h/v counters, data_req one cycle after the
// counters, de/hsync/vsync/frame_start two cycles after the counters.
// Ports: disp_clk, disp_rst, tg_en -> data_req, hsync, vsync, de,
// frame_start, pix_x, pix_y (coordinates only with DISP_TG_PIXEL_COORD_EN).
module disp_timing_gen
  import disp_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic             disp_clk,
  input  logic             disp_rst,
  input  logic             tg_en,
  output logic             data_req,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SB  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SB  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap;
  logic             v_wrap_unused;

  // Counters sit at 0 while disabled, so enabling always starts a frame.
  tg_axis_cnt #(
    .MODULO(H_TOTAL)
  ) u_h_cnt (
    .clk_i  (disp_clk),
    .rst_i  (disp_rst),
    .clr_i  (~tg_en),
    .inc_i  (tg_en),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap)
  );

  tg_axis_cnt #(
    .MODULO(V_TOTAL)
  ) u_v_cnt (
    .clk_i  (disp_clk),
    .rst_i  (disp_rst),
    .clr_i  (~tg_en),
    .inc_i  (h_wrap),
    .cnt_o  (v_cnt),
    .wrap_o (v_wrap_unused)
  );

  // Stage 1 decode, gated by tg_en so disabling flushes the pipe.
  logic act_d, hs1_d, vs1_d, fs1_d;
  logic act_q, hs1_q, vs1_q, fs1_q;

  always_comb begin
    act_d = tg_en && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs1_d = tg_en && (h_cnt >= H_SB) && (h_cnt < H_SE);
    vs1_d = tg_en && (v_cnt >= V_SB) && (v_cnt < V_SE);
    fs1_d = tg_en && (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge disp_clk) begin
    if (disp_rst) begin
      act_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      fs1_q <= 1'b0;
    end else begin
      act_q <= act_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      fs1_q <= fs1_d;
    end
  end

  // Stage 2: syncs are stored at pin level so outputs come straight
  // from flops.
  logic de_q, fs_q, hsync_q, vsync_q;
  logic hsync_d, vsync_d;

  always_comb begin
    hsync_d = hs1_q ? HS_POL : ~HS_POL;
    vsync_d = vs1_q ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge disp_clk) begin
    if (disp_rst) begin
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
    end else begin
      de_q    <= act_q;
      fs_q    <= fs1_q;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign data_req    = act_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

`ifdef DISP_TG_PIXEL_COORD_EN
  logic [CNT_W-1:0] x1_q, y1_q, x1_d, y1_d;
  logic [CNT_W-1:0] pix_x_q, pix_y_q;

  always_comb begin
    x1_d = act_d ? h_cnt : '0;
    y1_d = act_d ? v_cnt : '0;
  end

  always_ff @(posedge disp_clk) begin
    if (disp_rst) begin
      x1_q    <= '0;
      y1_q    <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      pix_x_q <= x1_q;
      pix_y_q <= y1_q;
    end
  end

  assign pix_x = pix_x_q;
  assign pix_y = pix_y_q;
`else
  assign pix_x = '0;
  assign pix_y = '0;
`endif

endmodule

// File: tb/tb_disp_timing_gen.sv
// Self-checking bench for disp_timing_gen on a scaled-down panel
// (28x17 total), one active-high and one active-low sync instance.
module tb_disp_timing_gen;

  localparam int HA  = 16;
  localparam int HFP = 4;
  localparam int HSW = 3;
  localparam int HBP = 5;
  localparam int VA  = 10;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b0;

  logic dr, hs, vs, de, fs;
  logic [11:0] px, py;
  logic dr_n, hs_n, vs_n, de_n, fs_n;
  logic [11:0] px_n, py_n;

  disp_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .disp_clk(clk), .disp_rst(rst), .tg_en(en),
    .data_req(dr), .hsync(hs), .vsync(vs), .de(de),
    .frame_start(fs), .pix_x(px), .pix_y(py)
  );

  disp_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .disp_clk(clk), .disp_rst(rst), .tg_en(en),
    .data_req(dr_n), .hsync(hs_n), .vsync(vs_n), .de(de_n),
    .frame_start(fs_n), .pix_x(px_n), .pix_y(py_n)
  );

  typedef struct {
    logic       dr;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [11:0] px;
    logic [11:0] py;
  } exp_t;

  typedef struct {
    bit r;
    bit e;
    int n;
    int de;
    int fs;
    int hs;
    int vs;
  } vec_t;

  exp_t s1q[$];
  int   mh = 0;
  int   mv = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   c_de, c_fs, c_hs, c_vs;

  function automatic exp_t stage(input bit on, input int h, input int v);
    exp_t e;
    e.dr = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.fs = 1'b0;
    e.px = '0;   e.py = '0;
    if (on) begin
      e.dr = (h < HA) && (v < VA);
      e.hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
      e.vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
      e.fs = (h == 0) && (v == 0);
`ifdef DISP_TG_PIXEL_COORD_EN
      if (e.dr) begin
        e.px = 12'(h);
        e.py = 12'(v);
      end
`endif
    end
    return e;
  endfunction

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // One clock: the model pushes the stage-1 prediction into the
  // scoreboard and pops the one that should now be on the outputs.
  task automatic tick(input bit r, input bit e);
    exp_t n, x;
    logic [28:0] got, want, got_n, want_n;
    rst = r;
    en  = e;
    @(posedge clk);
    cyc++;
    n = stage(!r && e, mh, mv);
    x = s1q.pop_front();
    if (r) x = stage(1'b0, 0, 0);
    s1q.push_back(n);
    if (r || !e) begin
      mh = 0;
      mv = 0;
    end else begin
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
    end
    #1;
    got    = {dr, de, hs, vs, fs, px, py};
    want   = {n.dr, x.dr, x.hs, x.vs, x.fs, x.px, x.py};
    got_n  = {dr_n, de_n, hs_n, vs_n, fs_n, px_n, py_n};
    want_n = {n.dr, x.dr, ~x.hs, ~x.vs, x.fs, x.px, x.py};
    checks++;
    if (got !== want || got_n !== want_n) begin
      errors++;
      $display("FAIL cycle %0d outputs: got %h/%h want %h/%h",
               cyc, got, got_n, want, want_n);
    end
    c_de += int'(de);
    c_fs += int'(fs);
    c_hs += int'(hs);
    c_vs += int'(vs);
  endtask

  vec_t tbl[7];

  initial begin
    int k1, k2, khs, lx, ly, found;
    tbl[0] = '{1'b1, 1'b1, 4,   0,   0, 0,  0};
    tbl[1] = '{1'b0, 1'b1, FT,  160, 1, 51, 56};
    tbl[2] = '{1'b0, 1'b1, FT,  160, 1, 51, 56};
    tbl[3] = '{1'b0, 1'b0, 5,   0,   0, 0,  0};
    tbl[4] = '{1'b0, 1'b1, 100, 63,  1, 9,  0};
    tbl[5] = '{1'b1, 1'b1, 2,   0,   0, 0,  0};
    tbl[6] = '{1'b0, 1'b1, 30,  17,  1, 3,  0};

    s1q.push_back(stage(1'b0, 0, 0));

    for (int i = 0; i < 7; i++) begin
      c_de = 0; c_fs = 0; c_hs = 0; c_vs = 0;
      repeat (tbl[i].n) tick(tbl[i].r, tbl[i].e);
      check($sformatf("vec%0d de count", i), c_de, tbl[i].de);
      check($sformatf("vec%0d fs count", i), c_fs, tbl[i].fs);
      check($sformatf("vec%0d hs count", i), c_hs, tbl[i].hs);
      check($sformatf("vec%0d vs count", i), c_vs, tbl[i].vs);
    end

    // Reset release: first frame_start, hsync start, frame period,
    // coordinates of the last de of the frame.
    tick(1'b1, 1'b1);
    k1 = 0; k2 = 0; khs = 0; lx = -1; ly = -1;
    for (int k = 1; k <= 2 * FT + 10 && k2 == 0; k++) begin
      tick(1'b0, 1'b1);
      if (fs && k1 == 0) k1 = k;
      else if (fs) k2 = k;
      if (hs && khs == 0) khs = k;
      if (de && k2 == 0) begin
        lx = int'(px);
        ly = int'(py);
      end
    end
    check("first frame_start cycle", k1, 2);
    check("first hsync cycle", khs, HA + HFP + 2);
    check("frame period", k2 - k1, FT);
`ifdef DISP_TG_PIXEL_COORD_EN
    check("last de pix_x", lx, HA - 1);
    check("last de pix_y", ly, VA - 1);
`else
    check("last de pix_x", lx, 0);
    check("last de pix_y", ly, 0);
`endif

    // Disable mid-line (line 5, pixel 10), then re-enable.
    tick(1'b1, 1'b1);
    repeat (5 * HT + 10) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("disable t1 data_req", int'(dr), 0);
    tick(1'b0, 1'b0);
    check("disable t2 de", int'(de), 0);
    check("disable t2 syncs", int'({hs, vs, fs}), 0);
    check("disable t2 syncs n", int'({hs_n, vs_n}), 3);
    tick(1'b0, 1'b1);
    check("reenable t1 fs", int'(fs), 0);
    tick(1'b0, 1'b1);
    check("reenable t2 fs", int'(fs), 1);
    check("reenable t2 de", int'(de), 1);
    check("reenable pix_y", int'(py), 0);

    // Reset pulse while vsync is active.
    found = 0;
    for (int k = 0; k < FT + 5 && found == 0; k++) begin
      tick(1'b0, 1'b1);
      if (vs) found = 1;
    end
    check("vsync reached", found, 1);
    tick(1'b1, 1'b1);
    check("rst vsync inactive", int'(vs), 0);
    check("rst vsync_n inactive", int'(vs_n), 1);
    tick(1'b0, 1'b1);
    check("post rst t1 fs", int'(fs), 0);
    tick(1'b0, 1'b1);
    check("post rst t2 fs", int'(fs), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
